sar_pulse_seq: RTL and testbench
================================

Name: sar_pulse_seq

Overview:
- Parametrised successor to the fixed 10-bit pulse shift register that sequences SAR bit trials.
- Launches a single one-hot token on a start request and walks it across N_BITS taps, one tap per clock.
- Direction is selectable per conversion, with busy, done and overrun status.
- Sits between the conversion-start logic and the SAR register/DAC bit-enable lines.

Parameters:
- N_BITS, 10, number of taps (SAR resolution); legal range 2..32.
- IDX_W, $clog2(N_BITS), width of o_tap_idx; derived, not overridden.

Ports:
- i_clk  in  1  clock; all state updates on rising edge.
- i_arstn  in  1  reset; asynchronous assert, active-low.
- i_start  in  1  conversion request; sampled on rising edge.
- i_dir  in  1  0 = MSB->LSB, 1 = LSB->MSB; sampled only when i_start is accepted.
- i_abort  in  1  synchronous abort of the current sequence.
- o_taps  out  N_BITS  one-hot active tap, or all-zero when idle.
- o_tap_idx  out  IDX_W  index of the active tap; 0 when idle.
- o_busy  out  1  high while a tap is active.
- o_done  out  1  one-cycle pulse after the final tap.
- o_overrun  out  1  one-cycle pulse when i_start arrives while busy.

Behaviour:
- Reset (i_arstn=0, asynchronous): state=IDLE, o_taps=0, o_tap_idx=0, o_busy=0, o_done=0, o_overrun=0, stored dir=0.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - i_start=1 and i_abort=0 -> SHIFT. Next cycle o_taps has bit N_BITS-1 set (dir=0) or bit 0 set (dir=1); o_tap_idx matches.
  - Latency from start edge to first tap: 1 cycle.
- SHIFT:
  - Each edge moves the token one position in the stored direction: >>1 for dir=0, <<1 for dir=1.
  - Each tap is held exactly 1 cycle, so N_BITS cycles of o_busy=1 in total.
  - After the last tap (bit 0 for dir=0, bit N_BITS-1 for dir=1) -> DONE. The token falls off; no wrap-around.
- DONE:
  - o_taps=0, o_busy=0, o_done=1 for exactly 1 cycle.
  - Then IDLE, unless i_start=1 in the DONE cycle: that start is accepted and the first tap appears next cycle (back-to-back, zero gap).
- i_start in SHIFT: ignored; the sequence is undisturbed; o_overrun=1 the next cycle.
- i_abort=1 in any state: next cycle IDLE, o_taps=0, o_busy=0, no o_done. Abort has priority over a simultaneous i_start, and no overrun is flagged.
- i_dir changes mid-sequence have no effect.
- Reset mid-sequence clears everything immediately; no done pulse is produced.
- All outputs are registered; no combinational path from inputs to outputs.

Optional Feature:
- Macro: SAR_PULSE_SEQ_STRETCH_EN.
- Defined: o_taps is thermometer-accumulated (pulse-stretcher mode). Every tap visited so far stays high until DONE.
  - Example, N_BITS=4, dir=0: 1000, 1100, 1110, 1111, then 0000 in DONE.
  - o_tap_idx still reports the newest tap.
- Undefined: pure one-hot behaviour as above.
- Timing of o_busy, o_done and o_overrun is identical in both builds.

Decomposition:
- Package sar_pkg holds:
  - seq_state_e (IDLE, SHIFT, DONE);
  - seq_dir_e (DIR_MSB_FIRST=0, DIR_LSB_FIRST=1);
  - localparam SAR_N_BITS_DEFAULT=10.
- Single module; no sub-module. The shifter is one always_ff with next-token logic.

Test Plan:
- Reset then i_start=1, i_dir=0, N_BITS=10 -> o_taps 10'b1000000000 ... 10'b0000000001 on 10 consecutive cycles, then o_taps=0 with o_done=1 for 1 cycle, o_busy low.
- i_start=1, i_dir=1 -> o_taps 10'b0000000001 through 10'b1000000000, o_tap_idx 0..9, then o_done.
- i_start pulsed at the 4th tap -> o_overrun=1 one cycle later; the sequence completes unchanged in 10 taps.
- i_start held high continuously -> taps repeat with no idle cycle: the done cycle is followed directly by the MSB tap; o_done pulses every 11 cycles.
- i_abort at the 5th tap (with i_start=1 same cycle) -> next cycle o_taps=0, o_busy=0, no o_done, no o_overrun. Also assert i_arstn=0 mid-sequence -> outputs cleared immediately.
- Build with SAR_PULSE_SEQ_STRETCH_EN, N_BITS=4, dir=0 -> o_taps 1000, 1100, 1110, 1111, then 0000 with o_done=1.

Source files
------------

// File: rtl/sar_pkg.sv
// Shared types for the SAR bit-trial pulse sequencer.
package sar_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } seq_state_e;

  typedef enum logic {
    DIR_MSB_FIRST = 1'b0,
    DIR_LSB_FIRST = 1'b1
  } seq_dir_e;

  localparam int unsigned SAR_N_BITS_DEFAULT = 10;

endpackage

// File: rtl/sar_pulse_seq.sv
// Walks a single token across N_BITS SAR bit-trial taps, one tap per clock.
// Define SAR_PULSE_SEQ_STRETCH_EN to keep visited taps high until DONE (thermometer output).
module sar_pulse_seq
  import sar_pkg::*;
#(
  parameter  int unsigned N_BITS = SAR_N_BITS_DEFAULT,
  localparam int unsigned IDX_W  = $clog2(N_BITS)
) (
  input  logic              i_clk,
  input  logic              i_arstn,
  input  logic              i_start,
  input  logic              i_dir,
  input  logic              i_abort,
  output logic [N_BITS-1:0] o_taps,
  output logic [IDX_W-1:0]  o_tap_idx,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_overrun
);

  localparam logic [N_BITS-1:0] TAP_ONE  = N_BITS'(1);
  localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(N_BITS - 1);

  seq_state_e state_q;
  seq_dir_e   dir_q;

  seq_dir_e          start_dir;
  logic [IDX_W-1:0]  first_idx;
  logic [IDX_W-1:0]  step_idx;
  logic [N_BITS-1:0] step_taps;
  logic              last_tap;

  // The active tap is tracked by index; the output vector is rebuilt from it.
  always_comb begin
    start_dir = seq_dir_e'(i_dir);
    first_idx = (start_dir == DIR_LSB_FIRST) ? '0 : IDX_LAST;
    last_tap  = (dir_q == DIR_LSB_FIRST) ? (o_tap_idx == IDX_LAST) : (o_tap_idx == '0);
    step_idx  = (dir_q == DIR_LSB_FIRST) ? o_tap_idx + IDX_W'(1) : o_tap_idx - IDX_W'(1);
`ifdef SAR_PULSE_SEQ_STRETCH_EN
    step_taps = o_taps | (TAP_ONE << step_idx);
`else
    step_taps = TAP_ONE << step_idx;
`endif
  end

  always_ff @(posedge i_clk or negedge i_arstn) begin
    if (!i_arstn) begin
      state_q   <= IDLE;
      dir_q     <= DIR_MSB_FIRST;
      o_taps    <= '0;
      o_tap_idx <= '0;
      o_busy    <= 1'b0;
      o_done    <= 1'b0;
      o_overrun <= 1'b0;
    end else begin
      o_done    <= 1'b0;
      o_overrun <= 1'b0;
      if (i_abort) begin
        state_q   <= IDLE;
        o_taps    <= '0;
        o_tap_idx <= '0;
        o_busy    <= 1'b0;
      end else begin
        case (state_q)
          // A start in the DONE cycle is accepted exactly like one in IDLE.
          IDLE, DONE: begin
            if (i_start) begin
              state_q   <= SHIFT;
              dir_q     <= start_dir;
              o_tap_idx <= first_idx;
              o_taps    <= TAP_ONE << first_idx;
              o_busy    <= 1'b1;
            end else begin
              state_q   <= IDLE;
              o_taps    <= '0;
              o_tap_idx <= '0;
              o_busy    <= 1'b0;
            end
          end
          SHIFT: begin
            o_overrun <= i_start;
            if (last_tap) begin
              state_q   <= DONE;
              o_taps    <= '0;
              o_tap_idx <= '0;
              o_busy    <= 1'b0;
              o_done    <= 1'b1;
            end else begin
              o_tap_idx <= step_idx;
              o_taps    <= step_taps;
            end
          end
          default: begin
            state_q   <= IDLE;
            o_taps    <= '0;
            o_tap_idx <= '0;
            o_busy    <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sar_pulse_seq.sv
// Directed bench for sar_pulse_seq (N_BITS=10); expectations follow SAR_PULSE_SEQ_STRETCH_EN.
module tb_sar_pulse_seq;

  localparam int unsigned N = 10;

  logic         clk = 1'b0;
  logic         arstn, start, dir, abort;
  logic [N-1:0] taps;
  logic [3:0]   idx;
  logic         busy, done, overrun;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  sar_pulse_seq #(.N_BITS(N)) dut (
    .i_clk     (clk),
    .i_arstn   (arstn),
    .i_start   (start),
    .i_dir     (dir),
    .i_abort   (abort),
    .o_taps    (taps),
    .o_tap_idx (idx),
    .o_busy    (busy),
    .o_done    (done),
    .o_overrun (overrun)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [N-1:0] exp_taps(input logic d, input int unsigned k);
    logic [N-1:0] v;
    v = '0;
`ifdef SAR_PULSE_SEQ_STRETCH_EN
    for (int unsigned j = 0; j <= k; j++) v[d ? j : N - 1 - j] = 1'b1;
`else
    v[d ? k : N - 1 - k] = 1'b1;
`endif
    return v;
  endfunction

  task automatic chk_tap(input logic d, input int unsigned k);
    chk($sformatf("taps d%0d k%0d", d, k), 64'(taps), 64'(exp_taps(d, k)));
    chk($sformatf("idx d%0d k%0d", d, k), 64'(idx), 64'(d ? k : N - 1 - k));
    chk("busy_high", 64'(busy), 64'(1));
    chk("done_low", 64'(done), 64'(0));
  endtask

  task automatic chk_done();
    chk("done_taps", 64'(taps), 64'(0));
    chk("done_busy", 64'(busy), 64'(0));
    chk("done_idx", 64'(idx), 64'(0));
    chk("done_pulse", 64'(done), 64'(1));
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_taps"}, 64'(taps), 64'(0));
    chk({tag, "_busy"}, 64'(busy), 64'(0));
    chk({tag, "_done"}, 64'(done), 64'(0));
    chk({tag, "_idx"}, 64'(idx), 64'(0));
  endtask

  // Full sequence; i_dir is flipped after launch to show it is ignored mid-run.
  task automatic run_seq(input logic d);
    start = 1'b1;
    dir   = d;
    tick();
    start = 1'b0;
    dir   = ~d;
    chk_tap(d, 0);
    for (int unsigned k = 1; k < N; k++) begin
      tick();
      chk_tap(d, k);
      chk("no_overrun", 64'(overrun), 64'(0));
    end
    tick();
    chk_done();
    tick();
    chk_idle("after_done");
  endtask

  initial begin
    arstn = 1'b0;
    start = 1'b0;
    dir   = 1'b0;
    abort = 1'b0;
    #3;
    chk_idle("reset");
    chk("reset_overrun", 64'(overrun), 64'(0));
    tick();
    arstn = 1'b1;
    tick();

    run_seq(1'b0);
    run_seq(1'b1);

    // start pulsed during the 4th tap
    start = 1'b1;
    dir   = 1'b0;
    tick();
    start = 1'b0;
    chk_tap(1'b0, 0);
    for (int unsigned k = 1; k < N; k++) begin
      tick();
      chk_tap(1'b0, k);
      chk($sformatf("overrun k%0d", k), 64'(overrun), 64'(k == 4 ? 1 : 0));
      start = (k == 3);
    end
    tick();
    chk_done();
    tick();
    chk_idle("ovr_end");

    // start held high: back-to-back sequences, done every N+1 cycles
    start = 1'b1;
    dir   = 1'b0;
    for (int unsigned rep = 0; rep < 2; rep++) begin
      for (int unsigned k = 0; k < N; k++) begin
        tick();
        chk_tap(1'b0, k);
      end
      tick();
      chk_done();
    end
    start = 1'b0;
    tick();
    chk_idle("held_end");

    // abort at the 5th tap together with start
    start = 1'b1;
    dir   = 1'b1;
    tick();
    start = 1'b0;
    chk_tap(1'b1, 0);
    for (int unsigned k = 1; k < 5; k++) begin
      tick();
      chk_tap(1'b1, k);
    end
    abort = 1'b1;
    start = 1'b1;
    tick();
    abort = 1'b0;
    start = 1'b0;
    chk_idle("abort");
    chk("abort_overrun", 64'(overrun), 64'(0));
    tick();
    chk_idle("abort_next");

    // asynchronous reset mid-sequence
    start = 1'b1;
    dir   = 1'b0;
    tick();
    start = 1'b0;
    tick();
    tick();
    chk_tap(1'b0, 2);
    #2;
    arstn = 1'b0;
    #1;
    chk_idle("arst_mid");
    tick();
    arstn = 1'b1;
    tick();
    chk_idle("arst_after");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
